simprisc_core: RTL and testbench
================================

Name: simprisc_core

Overview:
- Synthesizable SimpRISC execution core; the DUT that the SimpRISC UVM environment drives and checks.
- Upstream: the driver presents 16-bit instruction words over a valid/ready handshake (input monitor observes the same pins).
- Downstream: one write-back record per instruction, consumed by the output monitor and the scoreboard predictor/comparator.
- Serial multi-cycle core: 8-entry register file, fixed 4-state FSM, no pipelining, so no hazards exist.

Parameters:
- DATA_W, 8, register and ALU data width; only 8 is verified.
- NREGS, 8, register count; fixed by the 3-bit register fields.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word is valid.
- in_instr  in  16  instruction word.
- in_ready  out  1  core can accept an instruction.
- out_valid  out  1  one-cycle write-back pulse.
- out_rd  out  3  destination register index.
- out_data  out  DATA_W  result value.
- out_zero  out  1  result == 0.
- out_carry  out  1  carry (ADD/SHL) or borrow (SUB).
- out_err  out  1  illegal opcode.
- halted  out  1  sticky; set after HALT retires.

Behaviour:
- Instruction fields:
  - [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] reserved.
  - LDI uses [7:0] as imm8 and ignores rs1/rs2.
- Opcodes (carry is 0 unless stated):
  - 0 NOP: no register write.
  - 1 ADD: rd = rs1 + rs2; carry = bit 8 of the 9-bit sum.
  - 2 SUB: rd = rs1 - rs2 (mod 256); carry = (rs1 < rs2).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SHL: rd = rs1 << rs2[2:0]; carry = last bit shifted out (0 when shift is 0).
  - 7 SHR: logical right shift by rs2[2:0].
  - 8 LDI: rd = imm8.
  - 9 MOV: rd = rs1.
  - F HALT.
  - A-E illegal.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: in_ready = 1 when halted = 0.
  - A transfer occurs on a cycle with in_valid && in_ready. The word is latched and the next state is DECODE.
  - DECODE: operands are read from the register file.
  - EXEC: the ALU result and flags are registered.
  - WB: out_valid = 1 for exactly one cycle. Register write happens on the same edge.
  - in_ready = 0 in DECODE, EXEC and WB.
- Latency: an instruction accepted at edge N produces out_valid high during cycle N+3. Maximum throughput is 1 instruction per 4 cycles.
- No output backpressure: the consumer must always take the WB record.
- The out_* fields hold their values until the next WB. Only out_valid is pulsed.
- out_rd by instruction class:
  - ALU/LDI/MOV: out_rd = rd.
  - NOP, HALT, illegal: out_rd = 0, out_data = 0, out_zero = 0, out_carry = 0, and no register write.
- Illegal opcode: out_err = 1 in that WB only; registers are unchanged.
- NOP: WB record is still emitted with out_err = 0.
- HALT: WB record is emitted with out_err = 0. halted rises on the WB edge and stays set until reset; in_ready stays 0 while halted = 1.
- A register read after a write sees the new value, because the next DECODE is always at least 2 cycles after WB.
- Reset (asynchronous, any state):
  - FSM returns to IDLE and all registers clear to 0.
  - out_valid, out_rd, out_data, out_zero, out_carry, out_err and halted all go to 0.
  - An in-flight instruction is discarded and produces no WB.
  - in_ready = 1 from the first cycle after rst_n rises.
- While in_ready = 0, the core ignores in_valid. The driver holds the word until the handshake completes.

Test Plan:
- Reset, then LDI r1,0xF0 (0x82F0) accepted at edge N -> out_valid in cycle N+3 with rd=1, data=0xF0, zero=0, carry=0, err=0.
- Following that, LDI r2,0x20 (0x8420) then ADD r3,r1,r2 (0x1650) -> ADD record: rd=3, data=0x10, carry=1, zero=0.
- SUB r4,r2,r2 (0x2890) -> data=0x00, zero=1, carry=0. Then SUB r5,r2,r1 (0x2A88) -> data=0x30, carry=1.
- in_valid held high with back-to-back words -> in_ready pulses once per 4 cycles; exactly one WB per accepted word, in order.
- Illegal 0xA000, then MOV r6,r3 (0x9CC0) -> first record has err=1 and data=0. Second record has rd=6, data=0x10; r0 is unmodified.
- HALT (0xF000) -> WB record with err=0, then halted=1 and in_ready=0 for 20 cycles with in_valid high.
- Assert rst_n low during EXEC of ADD -> no out_valid. After reset, halted=0 and reading r1 via MOV returns 0x00.

Source files
------------

// File: rtl/simprisc_core.sv
// SimpRISC execution core: serial IDLE->DECODE->EXEC->WB machine with an
// 8-entry register file and one write-back record per accepted instruction.
module simprisc_core #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [15:0]       in_instr,
   output logic              in_ready,
   output logic              out_valid,
   output logic [2:0]        out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_zero,
   output logic              out_carry,
   output logic              out_err,
   output logic              halted
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
      OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
      OP_LDI = 4'h8, OP_MOV = 4'h9, OP_HLT = 4'hF
   } opcode_t;

   state_t              state_q, state_d;
   logic [15:0]         instr_q, instr_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [DATA_W-1:0]   regs_q [NREGS];
   logic [DATA_W-1:0]   regs_d [NREGS];
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [2:0]          out_rd_q, out_rd_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_zero_q, out_zero_d;
   logic                out_carry_q, out_carry_d;
   logic                out_err_q, out_err_d;
   logic                halted_q, halted_d;

   logic [3:0]          opcode;
   logic [2:0]          rd, rs1, rs2;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry;
   logic                alu_wr;
   logic                alu_err;
   logic                alu_halt;
   logic [DATA_W:0]     sum_w;
   logic [2*DATA_W-1:0] shl_w;
   logic [2:0]          sh;

   assign opcode = instr_q[15:12];
   assign rd     = instr_q[11:9];
   assign rs1    = instr_q[8:6];
   assign rs2    = instr_q[5:3];

   // ALU: result, carry/borrow and instruction class from the latched word and operands
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_wr    = 1'b1;
      alu_err   = 1'b0;
      alu_halt  = 1'b0;
      sh        = op_b_q[2:0];
      sum_w     = {1'b0, op_a_q} + {1'b0, op_b_q};
      // Carry of a left shift is whatever lands just above the data width.
      shl_w     = {{DATA_W{1'b0}}, op_a_q} << sh;
      case (opcode)
         OP_ADD: begin
            alu_res   = sum_w[DATA_W-1:0];
            alu_carry = sum_w[DATA_W];
         end
         OP_SUB: begin
            alu_res   = op_a_q - op_b_q;
            alu_carry = (op_a_q < op_b_q);
         end
         OP_AND: alu_res = op_a_q & op_b_q;
         OP_OR:  alu_res = op_a_q | op_b_q;
         OP_XOR: alu_res = op_a_q ^ op_b_q;
         OP_SHL: begin
            alu_res   = shl_w[DATA_W-1:0];
            alu_carry = shl_w[DATA_W];
         end
         OP_SHR: alu_res = op_a_q >> sh;
         OP_LDI: alu_res = DATA_W'(instr_q[7:0]);
         OP_MOV: alu_res = op_a_q;
         OP_NOP: alu_wr  = 1'b0;
         OP_HLT: begin
            alu_wr   = 1'b0;
            alu_halt = 1'b1;
         end
         default: begin
            alu_wr  = 1'b0;
            alu_err = 1'b1;
         end
      endcase
   end

   // Next-state logic for the FSM, operand latches, register file and write-back record
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      regs_d      = regs_q;
      in_ready_d  = in_ready_q;
      out_valid_d = 1'b0;
      out_rd_d    = out_rd_q;
      out_data_d  = out_data_q;
      out_zero_d  = out_zero_q;
      out_carry_d = out_carry_q;
      out_err_d   = out_err_q;
      halted_d    = halted_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               instr_d    = in_instr;
               in_ready_d = 1'b0;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            op_a_d  = regs_q[rs1];
            op_b_d  = regs_q[rs2];
            state_d = EXEC;
         end
         EXEC: begin
            // The record and the register write land on the edge entering WB,
            // so out_valid is high for exactly the WB cycle.
            out_valid_d = 1'b1;
            out_rd_d    = alu_wr ? rd : 3'd0;
            out_data_d  = alu_wr ? alu_res : '0;
            out_zero_d  = alu_wr && (alu_res == '0);
            out_carry_d = alu_wr && alu_carry;
            out_err_d   = alu_err;
            if (alu_wr) regs_d[rd] = alu_res;
            if (alu_halt) halted_d = 1'b1;
            state_d = WB;
         end
         WB: begin
            in_ready_d = !halted_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         instr_q     <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_rd_q    <= '0;
         out_data_q  <= '0;
         out_zero_q  <= 1'b0;
         out_carry_q <= 1'b0;
         out_err_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         regs_q      <= regs_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_rd_q    <= out_rd_d;
         out_data_q  <= out_data_d;
         out_zero_q  <= out_zero_d;
         out_carry_q <= out_carry_d;
         out_err_q   <= out_err_d;
         halted_q    <= halted_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_rd    = out_rd_q;
   assign out_data  = out_data_q;
   assign out_zero  = out_zero_q;
   assign out_carry = out_carry_q;
   assign out_err   = out_err_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_simprisc_core.sv
// Directed bench for simprisc_core: hand-computed write-back records checked
// cycle by cycle around each accepted instruction.
module tb_simprisc_core;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic [2:0]  out_rd;
   logic [7:0]  out_data;
   logic        out_zero;
   logic        out_carry;
   logic        out_err;
   logic        halted;

   int checks = 0;
   int errors = 0;

   simprisc_core #(.DATA_W(8), .NREGS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_rd    (out_rd),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .out_carry (out_carry),
      .out_err   (out_err),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a word, wait for the handshake, then check the record cycle by cycle.
   // Called on a negedge; returns on the negedge after the WB cycle.
   task automatic run(input string tag, input logic [15:0] instr, input bit hold,
                      input logic [2:0] rd, input logic [7:0] data,
                      input bit z, input bit c, input bit e,
                      input bit ready_after, input int max_wait);
      int waited;
      in_instr = instr;
      in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      chk({tag, "_wait"}, {31'd0, waited <= max_wait}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = hold;
      @(negedge clk);                        // DECODE
      chk({tag, "_dec_ov"},  {31'd0, out_valid}, 32'd0);
      chk({tag, "_dec_rdy"}, {31'd0, in_ready},  32'd0);
      @(negedge clk);                        // EXEC
      chk({tag, "_ex_ov"},   {31'd0, out_valid}, 32'd0);
      @(negedge clk);                        // WB
      chk({tag, "_wb_ov"},   {31'd0, out_valid}, 32'd1);
      chk({tag, "_wb_rdy"},  {31'd0, in_ready},  32'd0);
      chk({tag, "_rd"},      {29'd0, out_rd},    {29'd0, rd});
      chk({tag, "_data"},    {24'd0, out_data},  {24'd0, data});
      chk({tag, "_zero"},    {31'd0, out_zero},  {31'd0, z});
      chk({tag, "_carry"},   {31'd0, out_carry}, {31'd0, c});
      chk({tag, "_err"},     {31'd0, out_err},   {31'd0, e});
      @(negedge clk);                        // back in IDLE
      chk({tag, "_post_ov"},   {31'd0, out_valid}, 32'd0);
      chk({tag, "_post_rdy"},  {31'd0, in_ready},  {31'd0, ready_after});
      chk({tag, "_hold_data"}, {24'd0, out_data},  {24'd0, data});
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 16'h0000;
      #1;
      chk("rst_ov",     {31'd0, out_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted},    32'd0);
      chk("rst_data",   {24'd0, out_data},  32'd0);
      chk("rst_err",    {31'd0, out_err},   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // tag instr hold rd data z c e ready_after max_wait
      run("ldi_r1",  16'h82F0, 1'b0, 3'd1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      run("ldi_r2",  16'h8420, 1'b0, 3'd2, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      run("add_r3",  16'h1650, 1'b0, 3'd3, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 20);
      run("sub_r4",  16'h2890, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 20);
      run("sub_r5",  16'h2A88, 1'b0, 3'd5, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1, 20);

      // Back-to-back: in_valid never drops, each word accepted with no wait
      run("b2b_ldi_r7", 16'h8E05, 1'b1, 3'd7, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run("b2b_xor_r7", 16'h5FC8, 1'b1, 3'd7, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run("b2b_ldi_r6", 16'h8C04, 1'b1, 3'd6, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run("b2b_shl_r6", 16'h6C70, 1'b1, 3'd6, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 0);
      run("b2b_shr_r4", 16'h79F8, 1'b1, 3'd4, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run("b2b_and_r2", 16'h35C8, 1'b1, 3'd2, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run("b2b_or_r0",  16'h40F0, 1'b0, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 0);

      // Illegal / NOP produce empty records and leave registers alone
      run("illegal",   16'hA000, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 20);
      run("mov_r6_r3", 16'h9CC0, 1'b0, 3'd6, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      run("mov_r5_r0", 16'h9A00, 1'b0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      run("nop_rd7",   16'h0E00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      run("mov_r4_r7", 16'h99C0, 1'b0, 3'd4, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b1, 20);

      // HALT: record emitted, then the core refuses everything
      run("halt", 16'hF000, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      in_instr = 16'h8201;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halted_ready", {31'd0, in_ready},  32'd0);
         chk("halted_ov",    {31'd0, out_valid}, 32'd0);
      end
      chk("halted_sticky", {31'd0, halted}, 32'd1);
      in_valid = 1'b0;

      // Reset during EXEC of an ADD discards it
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_halted", {31'd0, halted},   32'd0);
      chk("rst2_ready",  {31'd0, in_ready}, 32'd1);
      run("ldi_r1_b", 16'h82F0, 1'b0, 3'd1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 20);
      in_instr = 16'h1650;
      in_valid = 1'b1;
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);                        // now in EXEC
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rst_ov", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_wb", {31'd0, out_valid}, 32'd0);
      end
      chk("abort_halted", {31'd0, halted},   32'd0);
      chk("abort_data",   {24'd0, out_data}, 32'd0);
      run("mov_r4_r1", 16'h9840, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
